// File: rtl/equivalence_comparator_pkg.sv
// Shared elaboration helpers for the pipelined masked equivalence comparator.
// Sizes the reduction tree from the chunk count and the fan-in.
package equivalence_comparator_pkg;

    // Number of reduction stages needed to fold n entries down to one.
    function automatic int clog2ceil_radix(input int n, input int r);
        int c;
        int s;
        c = n;
        s = 0;
        if (r < 2) return 0;
        while (c > 1) begin
            c = (c + r - 1) / r;
            s++;
        end
        return s;
    endfunction

    function automatic int idx_width(input int n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

    // Entry count left after s reduction stages.
    function automatic int entries_at(input int n, input int r, input int s);
        int c;
        c = n;
        for (int i = 0; i < s; i++) c = (c + r - 1) / r;
        return c;
    endfunction

endpackage

// File: rtl/equivalence_comparator_pipelined_if.sv
// Operand/result handshake bundle for the pipelined comparator.
// master drives operands and result-ready; slave is the comparator.
interface equivalence_comparator_if #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 2
);
    logic             i_vld;
    logic             i_rdy;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [WIDTH-1:0] i_m;
    logic             o_vld;
    logic             o_rdy;
    logic             o_eq;
    logic [IDXW-1:0]  o_idx;

    modport master (
        output i_vld, i_a, i_b, i_m, o_rdy,
        input  i_rdy, o_vld, o_eq, o_idx
    );

    modport slave (
        input  i_vld, i_a, i_b, i_m, o_rdy,
        output i_rdy, o_vld, o_eq, o_idx
    );
endinterface

// File: rtl/equivalence_comparator_pipelined_stage.sv
// One reduction level: folds RADIX-wide groups to the lowest mismatch,
// registered behind a valid bit that advances when downstream can take it.
module equivalence_comparator_stage
    import equivalence_comparator_pkg::*;
#(
    parameter  int NIN   = 4,
    parameter  int RADIX = 2,
    parameter  int IDXW  = 2,
    localparam int EW    = IDXW + 1,
    localparam int NOUT  = (NIN + RADIX - 1) / RADIX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_vld_i,
    input  logic             dn_adv_i,
    output logic             adv_o,
    output logic             vld_o,
    input  logic [NIN*EW-1:0]  data_i,
    output logic [NOUT*EW-1:0] data_o
);
    localparam int PADN = NOUT * RADIX;

    typedef struct packed {
        logic            mis;
        logic [IDXW-1:0] idx;
    } ent_t;

    ent_t [PADN-1:0] pad;
    ent_t [NOUT-1:0] data_d;
    ent_t [NOUT-1:0] data_q;
    logic            vld_q;
    logic            adv;

    // Padding entries of a partial last group read as matching.
    assign pad = (PADN*EW)'(data_i);

    assign adv    = ~vld_q | dn_adv_i;
    assign adv_o  = adv;
    assign vld_o  = vld_q;
    assign data_o = data_q;

    // Scan high to low so the lowest mismatching entry wins.
    always_comb begin
        data_d = '0;
        for (int g = 0; g < NOUT; g++) begin
            for (int j = RADIX - 1; j >= 0; j--) begin
                if (pad[g*RADIX+j].mis) data_d[g] = pad[g*RADIX+j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (adv) begin
            vld_q  <= up_vld_i;
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/equivalence_comparator_pipelined.sv
// Pipelined masked equivalence comparator: per-chunk mismatch flags in
// stage 0, then a RADIX-ary tree locating the lowest mismatching chunk.
module equivalence_comparator_pipelined
    import equivalence_comparator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int RADIX = 2
) (
    input logic clk,
    input logic rst,
    equivalence_comparator_if.slave bus
);
    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = idx_width(N);
    localparam int NS   = clog2ceil_radix(N, RADIX);
    localparam int L    = NS + 1;
    localparam int EW   = IDXW + 1;

    if (CHUNK < 1 || WIDTH < 1 || (WIDTH % CHUNK) != 0 || RADIX < 2) begin : g_bad
        $error("illegal WIDTH/CHUNK/RADIX combination");
    end

    typedef struct packed {
        logic            mis;
        logic [IDXW-1:0] idx;
    } ent_t;

    logic [WIDTH-1:0] diff;
    logic [N-1:0]     mis_d;
    logic [N-1:0]     mis_q;
    logic             v0_q;
    logic             acc;
    ent_t [N-1:0]     s0_ent;
    logic             vld [L];
    logic             adv [L];

    assign diff = (bus.i_a ^ bus.i_b) & bus.i_m;

    always_comb begin
        mis_d = '0;
        for (int k = 0; k < N; k++) mis_d[k] = |diff[k*CHUNK +: CHUNK];
    end

    assign bus.i_rdy = adv[0] & ~rst;
    assign acc       = bus.i_vld & bus.i_rdy;
    assign vld[0]    = v0_q;

    if (L == 1) begin : g_adv0_out
        assign adv[0] = ~v0_q | bus.o_rdy;
    end else begin : g_adv0_mid
        assign adv[0] = ~v0_q | adv[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q  <= 1'b0;
            mis_q <= '0;
        end else if (adv[0]) begin
            v0_q  <= acc;
            mis_q <= mis_d;
        end
    end

    // Chunk position becomes the index carried up the tree.
    always_comb begin
        s0_ent = '0;
        for (int k = 0; k < N; k++) begin
            s0_ent[k].mis = mis_q[k];
            s0_ent[k].idx = IDXW'(k);
        end
    end

    for (genvar s = 1; s < L; s++) begin : g_stg
        localparam int NIN  = entries_at(N, RADIX, s - 1);
        localparam int NOUT = entries_at(N, RADIX, s);

        logic [NIN*EW-1:0]  d_in;
        logic [NOUT*EW-1:0] d_out;
        logic               dn_adv;

        if (s == 1) begin : g_src0
            assign d_in = s0_ent;
        end else begin : g_srcn
            assign d_in = g_stg[s-1].d_out;
        end

        if (s == L - 1) begin : g_last
            assign dn_adv = bus.o_rdy;
        end else begin : g_mid
            assign dn_adv = adv[s+1];
        end

        equivalence_comparator_stage #(
            .NIN   (NIN),
            .RADIX (RADIX),
            .IDXW  (IDXW)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_vld_i (vld[s-1]),
            .dn_adv_i (dn_adv),
            .adv_o    (adv[s]),
            .vld_o    (vld[s]),
            .data_i   (d_in),
            .data_o   (d_out)
        );
    end

    assign bus.o_vld = vld[L-1];

    // o_eq is gated by valid so an idle or reset pipe reports 0.
    if (L == 1) begin : g_out0
        assign bus.o_eq  = v0_q & ~s0_ent[0].mis;
        assign bus.o_idx = '0;
    end else begin : g_outn
        ent_t fin;
        assign fin       = g_stg[L-1].d_out;
        assign bus.o_eq  = vld[L-1] & ~fin.mis;
        assign bus.o_idx = fin.idx;
    end
endmodule

// File: tb/tb_equivalence_comparator_pipelined.sv
// Directed and table-driven bench for the pipelined comparator
// (WIDTH=32, CHUNK=8, RADIX=2, latency 3).
module tb_equivalence_comparator_pipelined;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    equivalence_comparator_if #(.WIDTH(32), .IDXW(2)) bus ();

    equivalence_comparator_pipelined #(
        .WIDTH (32),
        .CHUNK (8),
        .RADIX (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] m;
        bit          eq;
        logic [1:0]  idx;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int n_emit = 0;
    bit lat_chk = 1'b1;
    bit cur_eq;
    logic [1:0] cur_idx;
    bit         q_eq  [$];
    logic [1:0] q_idx [$];
    int         q_cyc [$];
    int         emit_cyc [$];

    vec_t tv [9];
    vec_t bp [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] m, output bit eq,
                                  output logic [1:0] idx);
        logic [31:0] x;
        x   = (a ^ b) & m;
        eq  = 1'b1;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (x[k*8 +: 8] != 8'h00) begin
                eq  = 1'b0;
                idx = 2'(k);
            end
        end
    endfunction

    task automatic drive(input vec_t v, input logic vld);
        bus.i_a   = v.a;
        bus.i_b   = v.b;
        bus.i_m   = v.m;
        bus.i_vld = vld;
        cur_eq    = v.eq;
        cur_idx   = v.idx;
    endtask

    // One clock window: score emission, record acceptance, advance.
    task automatic cyc();
        logic acc;
        logic emit;
        bit e;
        logic [1:0] ei;
        int c;
        #1;
        acc  = bus.i_vld & bus.i_rdy;
        emit = bus.o_vld & bus.o_rdy;
        if (emit) begin
            n_emit++;
            emit_cyc.push_back(cyc_n);
            if (q_eq.size() == 0) begin
                chk("phantom_result", 32'd1, 32'd0);
            end else begin
                e  = q_eq.pop_front();
                ei = q_idx.pop_front();
                c  = q_cyc.pop_front();
                chk("o_eq", 32'(bus.o_eq), 32'(e));
                chk("o_idx", 32'(bus.o_idx), 32'(ei));
                if (lat_chk) chk("latency", 32'(cyc_n - c), 32'd3);
            end
        end
        if (acc) begin
            q_eq.push_back(cur_eq);
            q_idx.push_back(cur_idx);
            q_cyc.push_back(cyc_n);
        end
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm, input int bound);
        for (int k = 0; k < bound && q_eq.size() > 0; k++) cyc();
        if (q_eq.size() != 0) begin
            chk({nm, "_drain_timeout"}, 32'(q_eq.size()), 32'd0);
            q_eq.delete();
            q_idx.delete();
            q_cyc.delete();
        end
    endtask

    task automatic run_one(input vec_t v);
        drive(v, 1'b1);
        #1;
        chk("single_i_rdy", 32'(bus.i_rdy), 32'd1);
        cyc();
        bus.i_vld = 1'b0;
        drain("single", 8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int p;
        int n0;
        logic held_eq;
        logic [1:0] held_idx;
        logic acc_now;

        tv[0] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 2'd0};
        tv[1] = '{32'h12345678, 32'h12FF5670, 32'hFFFFFFFF, 1'b0, 2'd0};
        tv[2] = '{32'h12345678, 32'h12FF5670, 32'hFFFFFF00, 1'b0, 2'd2};
        tv[3] = '{32'h12345678, 32'h12FF5670, 32'hFF00FF00, 1'b1, 2'd0};
        tv[4] = '{32'h12345678, 32'h87654321, 32'h00000000, 1'b1, 2'd0};
        tv[5] = '{32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1'b0, 2'd3};
        tv[6] = '{32'hFFFFFFFF, 32'h00000000, 32'h00010000, 1'b0, 2'd2};
        tv[7] = '{32'h0000FF00, 32'h00000000, 32'hFFFFFFFF, 1'b0, 2'd1};
        tv[8] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFE, 1'b1, 2'd0};

        bp[0] = '{32'h000000FF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 2'd0};
        bp[1] = '{32'h0000FF00, 32'h00000000, 32'hFFFFFFFF, 1'b0, 2'd1};
        bp[2] = '{32'h00FF0000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 2'd2};
        bp[3] = '{32'hFF000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 2'd3};
        bp[4] = '{32'h12345678, 32'h12345678, 32'hFFFFFFFF, 1'b1, 2'd0};
        bp[5] = '{32'h01000100, 32'h00000000, 32'hFFFFFFFF, 1'b0, 2'd1};

        rst       = 1'b1;
        bus.o_rdy = 1'b1;
        v = '{32'h0, 32'h0, 32'hFFFFFFFF, 1'b1, 2'd0};
        drive(v, 1'b1);
        @(posedge clk);
        #1;

        // reset state, with i_vld held high
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rst_i_rdy", 32'(bus.i_rdy), 32'd0);
            chk("rst_o_vld", 32'(bus.o_vld), 32'd0);
            chk("rst_o_eq", 32'(bus.o_eq), 32'd0);
            chk("rst_o_idx", 32'(bus.o_idx), 32'd0);
            cyc();
        end
        rst       = 1'b0;
        bus.i_vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("post_rst_idle", 32'(bus.o_vld), 32'd0);
            cyc();
        end

        // table vectors, one at a time
        for (int i = 0; i < 9; i++) run_one(tv[i]);

        // backpressure: fill, stall, then release
        lat_chk = 1'b0;
        p  = 0;
        n0 = n_emit;
        held_eq  = 1'b0;
        held_idx = 2'd0;
        for (int w = 0; w < 40 && (p < 6 || q_eq.size() > 0); w++) begin
            bus.o_rdy = (w >= 5);
            if (p < 6) drive(bp[p], 1'b1);
            else bus.i_vld = 1'b0;
            #1;
            if (w == 3) begin
                held_eq  = bus.o_eq;
                held_idx = bus.o_idx;
                chk("bp_full_o_vld", 32'(bus.o_vld), 32'd1);
            end
            if (w == 4) begin
                chk("bp_accepted", 32'(p), 32'd3);
                chk("bp_full_i_rdy", 32'(bus.i_rdy), 32'd0);
                chk("bp_hold_eq", 32'(bus.o_eq), 32'(held_eq));
                chk("bp_hold_idx", 32'(bus.o_idx), 32'(held_idx));
                chk("bp_hold_vld", 32'(bus.o_vld), 32'd1);
            end
            if (w == 5) chk("bp_acc_emit_i_rdy", 32'(bus.i_rdy), 32'd1);
            acc_now = bus.i_vld & bus.i_rdy;
            cyc();
            if (acc_now) p++;
        end
        chk("bp_emit_count", 32'(n_emit - n0), 32'd6);
        chk("bp_queue_empty", 32'(q_eq.size()), 32'd0);
        lat_chk = 1'b1;

        // streaming, one result per cycle
        bus.o_rdy = 1'b1;
        emit_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            v.a = $urandom;
            v.b = v.a ^ ($urandom & $urandom & $urandom);
            v.m = $urandom | $urandom;
            model(v.a, v.b, v.m, v.eq, v.idx);
            drive(v, 1'b1);
            #1;
            chk("stream_i_rdy", 32'(bus.i_rdy), 32'd1);
            cyc();
        end
        bus.i_vld = 1'b0;
        drain("stream", 8);
        chk("stream_count", 32'(emit_cyc.size()), 32'd10);
        if (emit_cyc.size() == 10)
            chk("stream_back_to_back", 32'(emit_cyc[9] - emit_cyc[0]), 32'd9);

        // reset with two transactions in flight
        drive(bp[1], 1'b1);
        cyc();
        drive(bp[3], 1'b1);
        cyc();
        rst = 1'b1;
        drive(bp[2], 1'b1);
        #1;
        chk("midrst_i_rdy", 32'(bus.i_rdy), 32'd0);
        cyc();
        q_eq.delete();
        q_idx.delete();
        q_cyc.delete();
        rst       = 1'b0;
        bus.i_vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("midrst_o_vld", 32'(bus.o_vld), 32'd0);
            cyc();
        end
        run_one(tv[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/equivalence_comparator_pipelined.md
Name: equivalence_comparator_pipelined

Overview:
- Parametrised, pipelined successor to the combinational equivalence comparator.
- Compares two WIDTH-bit operands under a per-bit mask.
- Reports equality and the index of the lowest mismatching CHUNK-wide segment.
- Pipelined reduction tree with valid/ready handshakes on both sides, for wide datapaths (compare units, tag match, CAM lookup) at high clock rates. Full throughput: one compare per cycle.

Parameters:
- WIDTH, 32: operand width in bits. WIDTH % CHUNK == 0 is required.
- CHUNK, 8: segment width compared in stage 0. N = WIDTH/CHUNK.
- RADIX, 2: fan-in of each reduction stage. RADIX >= 2 is required.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- i_vld  in  1  input transaction valid
- i_rdy  out  1  input ready
- i_a  in  WIDTH  operand A
- i_b  in  WIDTH  operand B
- i_m  in  WIDTH  compare mask; 1 = bit compared, 0 = bit ignored
- o_vld  out  1  result valid
- o_rdy  in  1  result ready
- o_eq  out  1  1 when all masked bits of A and B are equal
- o_idx  out  IDXW  lowest mismatching chunk index. IDXW = max(1, clog2(N)).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. Elaboration error on an illegal WIDTH/CHUNK/RADIX.
- Stage 0 registers per-chunk flags: mis[k] = |((i_a ^ i_b) & i_m) over chunk k. Chunk k covers bits k*CHUNK +: CHUNK.
- Each later stage combines groups of RADIX entries from the previous stage:
  - mis_out = OR of the group.
  - idx_out = index of the lowest-indexed mismatching entry in the group.
  - A partial last group is allowed; absent entries count as matching.
- Latency L = 1 + ceil(log_RADIX(N)) cycles from the i_vld&i_rdy edge to o_vld. N=1 gives L=1. Defaults give L=3.
- o_eq = ~mis of the final stage. o_idx = idx of the final stage; o_idx = 0 when o_eq = 1.
- Handshake:
  - Each stage s has a valid bit v[s]. adv[L-1] = ~v[L-1] | o_rdy. For s < L-1: adv[s] = ~v[s] | adv[s+1].
  - Stage s loads when adv[s]. Its valid becomes the upstream valid; at stage 0 that is i_vld & i_rdy.
  - i_rdy = adv[0] & ~rst. The ready path o_rdy -> i_rdy is combinational.
- Capacity: L transactions in flight. i_rdy = 0 exactly when all v = 1 and o_rdy = 0.
- Ordering: results leave in acceptance order, with no loss or duplication.
- Output stability: while o_vld = 1 and o_rdy = 0, o_eq and o_idx hold.
- Full throughput: with o_rdy held at 1, one result per cycle.
- Reset:
  - All v[s] = 0, o_vld = 0, o_eq = 0, o_idx = 0. Data registers clear to 0.
  - i_rdy = 0 while rst = 1; inputs are not captured.
  - Reset mid-operation discards all in-flight transactions; none are emitted afterwards.
- All-zero mask: o_eq = 1, o_idx = 0.
- Simultaneous accept and emit in the same cycle with the pipe full and o_rdy = 1: legal, and occupancy is unchanged.

Decomposition:
- Package equivalence_comparator_pkg:
  - function clog2ceil_radix(n, r), returning the stage count.
  - function idx_width(n).
  - typedef struct packed {logic mis; logic [IDXW-1:0] idx;} for stage entries (parametrised via a localparam in the module).
- Sub-module equivalence_comparator_stage (RADIX-in reduce plus register plus valid/adv logic). Instantiate it L-1 times in a generate loop. Stage 0 is inline.

Test Plan (WIDTH=32, CHUNK=8, RADIX=2; L=3, IDXW=2):
1. rst=1 for 2 cycles with i_vld=1, a=b=0 -> i_rdy=0, o_vld=0, o_eq=0, o_idx=0. After release, no phantom result.
2. a=b=0xDEADBEEF, m=0xFFFFFFFF, o_rdy=1 -> o_vld=1 exactly 3 cycles after accept, o_eq=1, o_idx=0.
3. a=0x12345678, b=0x12FF5670, m=0xFFFFFFFF -> o_eq=0, o_idx=0. With m=0xFFFFFF00 -> o_eq=0, o_idx=2. With m=0xFF00FF00 -> o_eq=1, o_idx=0.
4. Backpressure: 6 back-to-back transactions, o_rdy=0 for 5 cycles, then 1 -> exactly 3 accepted before i_rdy=0. Outputs held stable. All 6 results emerge in order, none dropped or duplicated.
5. Streaming with o_rdy=1 and i_vld=1 for 10 random vectors -> 10 consecutive o_vld cycles. Results match a reference model (masked compare, lowest mismatching chunk).
6. Reset mid-operation: 2 transactions in flight, rst pulse 1 cycle -> o_vld=0 the next cycle. The in-flight results never appear. A new transaction after release completes with L=3.
